// File: rtl/accum_job_pkg.sv
// accum_job_pkg: shared widths, types and FSM state encodings for the accumulation job controller
package accum_job_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_LEN_W  = 9;
  typedef logic [DEF_DATA_W-1:0] data_t;
  typedef logic [DEF_ADDR_W-1:0] addr_t;
  typedef logic [DEF_LEN_W-1:0]  len_t;
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_RUN   = 2'd1;
  localparam state_t S_DRAIN = 2'd2;
  localparam state_t S_DONE  = 2'd3;
endpackage

// File: rtl/acc_core.sv
// acc_core: unsigned accumulator register with carry detect; ACC_SAT_EN selects saturate instead of wrap
module acc_core #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] acc_o,
  output logic              ovf_pulse_o
);
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W:0]   sum;
  always_comb begin
    sum = {1'b0, acc_q} + {1'b0, din_i};
`ifdef ACC_SAT_EN
    acc_d = clr_i ? '0 : en_i ? (sum[DATA_W] ? '1 : sum[DATA_W-1:0]) : acc_q;
`else
    acc_d = clr_i ? '0 : en_i ? sum[DATA_W-1:0] : acc_q;
`endif
  end
  assign ovf_pulse_o = en_i & ~clr_i & sum[DATA_W];
  assign acc_o = acc_q;
  always_ff @(posedge clk)
    acc_q <= rst ? '0 : acc_d;
endmodule

// File: rtl/accum_job_ctrl.sv
// accum_job_ctrl: sequences one accumulation job over a 1-cycle-latency operand RAM.
// Build option ACC_SAT_EN (in acc_core) saturates the sum instead of wrapping.
module accum_job_ctrl
  import accum_job_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_base,
  input  logic [LEN_W-1:0]  start_len,
  input  logic              abort,
  output logic              busy,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              ovf
);
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  len_q, len_d, idx_q, idx_d;
  logic [DATA_W-1:0] acc, result_q;
  logic              rd_en_q, ovf_job_q, ovf_q, clr, ovf_pulse;
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    idx_d   = idx_q;
    clr     = 1'b0;
    if (state_q == S_IDLE) begin
      if (start) begin
        base_d  = start_base;
        len_d   = start_len;
        idx_d   = '0;
        clr     = 1'b1;
        state_d = (start_len == '0) ? S_DONE : S_RUN;
      end
    end else if (abort) begin
      state_d = S_IDLE;
    end else if (state_q == S_RUN) begin
      idx_d   = idx_q + 1'b1;
      state_d = (idx_q == len_q - 1'b1) ? S_DRAIN : S_RUN;
    end else begin
      state_d = (state_q == S_DRAIN) ? S_DONE : S_IDLE;
    end
  end
  assign busy    = state_q != S_IDLE;
  assign rd_en   = (state_q == S_RUN) & ~abort;
  assign rd_addr = base_q + ADDR_W'(idx_q);
  assign done    = (state_q == S_DONE) & ~abort;
  // The final sum is live from the accumulator during DONE, then held in result_q.
  assign result  = done ? acc : result_q;
  assign ovf     = done ? ovf_job_q : ovf_q;
  acc_core #(.DATA_W(DATA_W)) u_acc (
    .clk         (clk),
    .rst         (rst),
    .clr_i       (clr),
    .en_i        (rd_en_q & ~abort),
    .din_i       (rd_data),
    .acc_o       (acc),
    .ovf_pulse_o (ovf_pulse)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      rd_en_q   <= 1'b0;
      ovf_job_q <= 1'b0;
      result_q  <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      rd_en_q   <= rd_en;
      ovf_job_q <= clr ? 1'b0 : (ovf_job_q | ovf_pulse);
      if (done) begin
        result_q <= acc;
        ovf_q    <= ovf_job_q;
      end
    end
  end
endmodule

// File: tb/tb_accum_job_ctrl.sv
// tb_accum_job_ctrl: directed self-checking bench with a 1-cycle operand RAM model
module tb_accum_job_ctrl;
`ifdef ACC_SAT_EN
  localparam logic [7:0] WRAP_RES = 8'd255;
`else
  localparam logic [7:0] WRAP_RES = 8'd54;
`endif
  logic       clk = 1'b0;
  logic       rst = 1'b1, start = 1'b0, abort = 1'b0;
  logic [7:0] start_base = '0, rd_addr, rd_data, result;
  logic [8:0] start_len = '0;
  logic       busy, rd_en, done, ovf;
  logic [7:0] mem [256];
  int checks = 0, failures = 0;

  accum_job_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .start_base(start_base), .start_len(start_len),
    .abort(abort), .busy(busy), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .done(done), .result(result), .ovf(ovf)
  );

  always #5 clk = ~clk;
  // Garbage on rd_data when no read is in flight.
  always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : 8'($urandom);

  task automatic run_job(input logic [7:0] b, input logic [8:0] l, input logic [7:0] er,
                         input logic eo, input int spur, input bit poke, input string nm);
    int cyc = 0;
    bit seen = 0;
    int ecyc = (l == 0) ? 1 : int'(l) + 2;
    logic [7:0] ea;
    @(negedge clk);
    start = 1'b1; start_base = b; start_len = l;
    while (!seen && cyc < 600) begin
      @(negedge clk);
      cyc++;
      start = (cyc == spur); start_base = 8'h20; start_len = 9'd8;
      checks++;
      if (rd_en !== (cyc >= 1 && cyc <= int'(l))) begin
        failures++; $display("FAIL %s rd_en cyc=%0d got=%b", nm, cyc, rd_en);
      end
      if (cyc >= 1 && cyc <= int'(l)) begin
        ea = b + 8'(cyc - 1);
        checks++;
        if (rd_addr !== ea) begin
          failures++; $display("FAIL %s rd_addr cyc=%0d got=%h exp=%h", nm, cyc, rd_addr, ea);
        end
      end
      if (done === 1'b1) begin
        seen = 1;
        checks += 3;
        if (cyc != ecyc) begin
          failures++; $display("FAIL %s done_cycle got=%0d exp=%0d", nm, cyc, ecyc);
        end
        if (result !== er) begin
          failures++; $display("FAIL %s result got=%0d exp=%0d", nm, result, er);
        end
        if (ovf !== eo) begin
          failures++; $display("FAIL %s ovf got=%b exp=%b", nm, ovf, eo);
        end
        if (poke) start = 1'b1;
      end
    end
    if (!seen) begin
      checks++; failures++; $display("FAIL %s timeout waiting for done", nm);
    end
    @(negedge clk);
    start = 1'b0;
    checks += 3;
    if (busy !== 1'b0) begin failures++; $display("FAIL %s busy_after got=%b exp=0", nm, busy); end
    if (done !== 1'b0) begin failures++; $display("FAIL %s done_width got=%b exp=0", nm, done); end
    if (result !== er || ovf !== eo) begin
      failures++; $display("FAIL %s hold got=%0d/%b exp=%0d/%b", nm, result, ovf, er, eo);
    end
    if (poke) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin failures++; $display("FAIL %s start_in_done busy got=%b exp=0", nm, busy); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, rd_en, done, ovf, result, rd_addr} !== 20'h0) begin
      failures++;
      $display("FAIL reset busy=%b rd_en=%b done=%b ovf=%b result=%h rd_addr=%h exp all 0",
               busy, rd_en, done, ovf, result, rd_addr);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) mem[8'h10 + i] = 8'(i + 1);
    run_job(8'h10, 9'd4, 8'd10, 1'b0, 0, 0, "basic");
  endtask

  task automatic test_len0();
    run_job(8'h00, 9'd0, 8'd0, 1'b0, 0, 0, "len0");
  endtask

  task automatic test_wrap();
    mem[8'hFE] = 8'd200; mem[8'hFF] = 8'd100; mem[8'h00] = 8'd10;
    run_job(8'hFE, 9'd3, WRAP_RES, 1'b1, 0, 0, "wrap");
  endtask

  task automatic test_abort();
    int dones = 0;
    for (int i = 0; i < 8; i++) mem[8'h20 + i] = 8'(i + 1);
    @(negedge clk);
    start = 1'b1; start_base = 8'h20; start_len = 9'd8;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    #1;
    checks += 2;
    if (rd_en !== 1'b0) begin failures++; $display("FAIL abort rd_en_drop got=%b exp=0", rd_en); end
    if (busy !== 1'b1) begin failures++; $display("FAIL abort busy_before got=%b exp=1", busy); end
    @(negedge clk);
    abort = 1'b0;
    checks += 2;
    if (busy !== 1'b0) begin failures++; $display("FAIL abort busy_after got=%b exp=0", busy); end
    if (result !== WRAP_RES || ovf !== 1'b1) begin
      failures++; $display("FAIL abort keep got=%0d/%b exp=%0d/1", result, ovf, WRAP_RES);
    end
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin failures++; $display("FAIL abort no_done got=%0d exp=0", dones); end
    run_job(8'h20, 9'd8, 8'd36, 1'b0, 0, 0, "after_abort");
  endtask

  task automatic test_start_ignored();
    run_job(8'h10, 9'd4, 8'd10, 1'b0, 2, 1, "start_ignored");
  endtask

  task automatic test_rst_mid();
    @(negedge clk);
    start = 1'b1; start_base = 8'h20; start_len = 9'd8;
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy, rd_en, done, ovf, result, rd_addr} !== 20'h0) begin
      failures++;
      $display("FAIL rst_mid busy=%b rd_en=%b done=%b ovf=%b result=%h rd_addr=%h exp all 0",
               busy, rd_en, done, ovf, result, rd_addr);
    end
    run_job(8'h10, 9'd4, 8'd10, 1'b0, 0, 0, "after_rst");
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
    test_reset();
    test_basic();
    test_len0();
    test_wrap();
    test_abort();
    test_start_ignored();
    test_rst_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
